alu_issue_queue: RTL and testbench
==================================

// Module: alu_issue_queue
// PURPOSE
//  Upstream issue stage for sync_alu: buffers {A,B,op,tag} requests behind a valid/ready port and drives registered operands into sync_alu.
//  Tracks the two-cycle operand->Z pipeline and retires tagged {Z,overflow} results into a response buffer with valid/ready.
//  Credit-based issue guarantees no result is ever lost while rsp_ready is low.
// PARAMETERS
//  IQ_DEPTH    4   request FIFO entries (power of 2, >=2)
//  RBUF_DEPTH  4   response buffer entries (power of 2, >=3 for full throughput)
//  TAG_WIDTH   4   opaque request tag carried to the response
// PORTS
//  clk        in   1             clock, all state on rising edge
//  rst        in   1             synchronous reset, active-high
//  req_valid  in   1             request present
//  req_ready  out  1             request accepted when req_valid && req_ready
//  req_a      in   DATA_WIDTH    operand A
//  req_b      in   DATA_WIDTH    operand B
//  req_op     in   ALU_OP_WIDTH  ALU operation code
//  req_tag    in   TAG_WIDTH     request tag
//  alu_a      out  DATA_WIDTH    registered operand to sync_alu A
//  alu_b      out  DATA_WIDTH    registered operand to sync_alu B
//  alu_op     out  ALU_OP_WIDTH  registered op to sync_alu aluctrl
//  alu_z      in   DATA_WIDTH    sync_alu Z
//  alu_ovf    in   1             sync_alu overflow
//  rsp_valid  out  1             response buffer non-empty
//  rsp_ready  in   1             response popped when rsp_valid && rsp_ready
//  rsp_z      out  DATA_WIDTH    result at buffer head
//  rsp_ovf    out  1             overflow at buffer head
//  rsp_tag    out  TAG_WIDTH     tag at buffer head
//  busy       out  1             any request queued, in flight or buffered
// BEHAVIOUR
//  Reset: IQ and RBUF empty, pointers 0, p1/p2 valid bits 0, alu_a/alu_b/alu_op 0, rsp_* 0, req_ready 1, busy 0.
//  req_ready = !iq_full (independent of same-cycle pop; no write into a full IQ).
//  Pipeline: issue edge loads alu_* and sets p1 (tag captured); next edge p2 <= p1 (sync_alu Z now valid); next edge p2 writes {alu_z,alu_ovf,tag} into RBUF.
//  Non-issue cycles: alu_* hold last values; sync_alu output is ignored unless p2=1.
//  Issue condition: IQ non-empty && (rcount + p1 + p2 - rsp_pop) < RBUF_DEPTH; at most one issue/cycle, in order.
//  Latency: accept at edge t -> issue at t+1 -> rsp_valid high after edge t+3 (IQ and RBUF empty, rsp_ready high).
//  Throughput: one result/cycle sustained when rsp_ready stays high.
//  Simultaneous RBUF write and pop: rcount unchanged; pop from empty never occurs (gated by rsp_valid).
//  Pointers wrap modulo depth; full/empty from extra MSB on each pointer.
//  rsp_z/ovf/tag are combinational reads of the RBUF head; hold stable while rsp_valid && !rsp_ready.
//  Mid-operation reset: all queued, in-flight and buffered entries dropped; no response appears after rst deasserts.
//  busy = !iq_empty || p1 || p2 || rsp_valid.
// CONFIGURATION
//  ALU_ISSUE_BYPASS_EN defined: when IQ empty and issue condition (ignoring IQ) holds, an accepted request loads alu_* in its accepting cycle (skips IQ); latency t -> rsp_valid after t+2.
//  Not defined: every request passes through IQ; latency 3 as above. Ordering preserved in both.
// STRUCTURE
//  DATA_WIDTH, ALU_OP_WIDTH from the shared define.v; add TAG_WIDTH default and IQ/RBUF depth defaults there.
//  One sub-module: sync_fifo (parameterised width/depth, sync active-high reset, count output), instanced for IQ and RBUF.
//  Integration: sync_alu rst_n tied to ~rst at the top level.
// TESTING
//  Single op: ADD a=5 b=3 tag=1, rsp_ready=1 -> rsp_valid after edge t+3, rsp_z=8, ovf=0, rsp_tag=1.
//  Back-to-back 8 requests tags 0..7, rsp_ready=1 -> 8 responses in tag order on consecutive cycles.
//  rsp_ready=0 while 10 requests offered -> RBUF fills to 4, IQ to 4, req_ready=0; no drop; release -> tags 0..7 in order, then remaining.
//  Signed overflow ADD 0x7FFF..F + 1 -> rsp_ovf=1, rsp_z=0x800..0.
//  rst pulsed 1 cycle with 3 ops in flight -> busy=0 next cycle, no rsp_valid afterwards, req_ready=1.
//  ALU_ISSUE_BYPASS_EN build: single op into idle block -> rsp_valid after edge t+2.

Source files
------------

// File: rtl/alu_issue_queue_pkg.sv
// Shared widths, depth defaults and request/response records for the ALU issue queue.
// Optional feature macro: ALU_ISSUE_BYPASS_EN (used in alu_issue_queue.sv).
package alu_issue_queue_pkg;

    localparam int DATA_WIDTH      = 16;
    localparam int ALU_OP_WIDTH    = 4;
    localparam int TAG_WIDTH       = 4;
    localparam int DEF_IQ_DEPTH    = 4;
    localparam int DEF_RBUF_DEPTH  = 4;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3
    } alu_op_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   a;
        logic [DATA_WIDTH-1:0]   b;
        logic [ALU_OP_WIDTH-1:0] op;
        logic [TAG_WIDTH-1:0]    tag;
    } req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] z;
        logic                  ovf;
        logic [TAG_WIDTH-1:0]  tag;
    } rsp_t;

endpackage

// File: rtl/alu_issue_queue_if.sv
// Request/response valid-ready port of the ALU issue queue.
// master = client issuing requests and draining responses; slave = the queue.
interface alu_issue_queue_if;
    import alu_issue_queue_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic [DATA_WIDTH-1:0]   req_a;
    logic [DATA_WIDTH-1:0]   req_b;
    logic [ALU_OP_WIDTH-1:0] req_op;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_z;
    logic                    rsp_ovf;
    logic [TAG_WIDTH-1:0]    rsp_tag;

    modport master (
        output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_z, rsp_ovf, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_z, rsp_ovf, rsp_tag
    );

endinterface

// File: rtl/alu_issue_queue_sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, extra-MSB pointers; head read is combinational
// and forced to zero when empty so an idle queue presents all-zero data.
module alu_issue_queue_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, empty, wr_ok, rd_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Issue stage in front of sync_alu: request FIFO, registered operands, 2-stage result
// tracker and credit-guarded response buffer. ALU_ISSUE_BYPASS_EN lets an idle queue skip the IQ.
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int IQ_DEPTH   = DEF_IQ_DEPTH,
    parameter int RBUF_DEPTH = DEF_RBUF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    alu_issue_queue_if.slave        io,
    output logic [DATA_WIDTH-1:0]   alu_a,
    output logic [DATA_WIDTH-1:0]   alu_b,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]   alu_z,
    input  logic                    alu_ovf,
    output logic                    busy
);

    localparam int IAW = $clog2(IQ_DEPTH);
    localparam int RAW = $clog2(RBUF_DEPTH);
    localparam int CW  = RAW + 2;

    req_t                      req_in, iq_head, iss;
    rsp_t                      rbuf_wr, rbuf_head;
    logic [IAW:0]              iq_count;
    logic [RAW:0]              rcount;
    logic [1:0]                vld_pipe;
    logic [1:0][TAG_WIDTH-1:0] tag_pipe;
    logic [CW-1:0]             inflight;
    logic iq_empty, iq_full, req_fire, rsp_pop, credit_ok, iq_issue, bypass, issue;

    assign iq_empty     = (iq_count == '0);
    assign iq_full      = (iq_count == (IAW+1)'(IQ_DEPTH));
    assign io.req_ready = !iq_full;
    assign req_fire     = io.req_valid && !iq_full;
    assign io.rsp_valid = (rcount != '0);
    assign rsp_pop      = io.rsp_valid && io.rsp_ready;

    // Every issued op owns an RBUF slot from issue until it is popped.
    assign inflight  = CW'(rcount) + CW'(vld_pipe[0]) + CW'(vld_pipe[1]) - CW'(rsp_pop);
    assign credit_ok = (inflight < CW'(RBUF_DEPTH));
    assign iq_issue  = !iq_empty && credit_ok;

`ifdef ALU_ISSUE_BYPASS_EN
    assign bypass = iq_empty && credit_ok && req_fire;
`else
    assign bypass = 1'b0;
`endif

    assign issue  = iq_issue || bypass;
    assign req_in = '{a: io.req_a, b: io.req_b, op: io.req_op, tag: io.req_tag};
    assign iss    = bypass ? req_in : iq_head;

    alu_issue_queue_sync_fifo #(.WIDTH($bits(req_t)), .DEPTH(IQ_DEPTH)) u_iq (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (req_fire && !bypass),
        .wr_data (req_in),
        .rd_en   (iq_issue),
        .rd_data (iq_head),
        .count   (iq_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[0], issue};
            tag_pipe[1] <= tag_pipe[0];
            if (issue) begin
                alu_a       <= iss.a;
                alu_b       <= iss.b;
                alu_op      <= iss.op;
                tag_pipe[0] <= iss.tag;
            end
        end
    end

    // Stage 2 means sync_alu Z corresponds to the tracked tag this cycle.
    assign rbuf_wr = '{z: alu_z, ovf: alu_ovf, tag: tag_pipe[1]};

    alu_issue_queue_sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RBUF_DEPTH)) u_rbuf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (vld_pipe[1]),
        .wr_data (rbuf_wr),
        .rd_en   (rsp_pop),
        .rd_data (rbuf_head),
        .count   (rcount)
    );

    assign io.rsp_z   = rbuf_head.z;
    assign io.rsp_ovf = rbuf_head.ovf;
    assign io.rsp_tag = rbuf_head.tag;
    assign busy       = !iq_empty || (|vld_pipe) || io.rsp_valid;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural one-register sync_alu model.
module tb_alu_issue_queue;
    import alu_issue_queue_pkg::*;

`ifdef ALU_ISSUE_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [DATA_WIDTH-1:0]   alu_a, alu_b, alu_z;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic                    alu_ovf, busy, alu_rst_n;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_issue_queue_if io ();

    alu_issue_queue dut (
        .clk     (clk),
        .rst     (rst),
        .io      (io),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_z   (alu_z),
        .alu_ovf (alu_ovf),
        .busy    (busy)
    );

    // sync_alu stand-in: Z/overflow registered one edge after operands.
    function automatic logic [DATA_WIDTH:0] alu_f(input logic [DATA_WIDTH-1:0] a, b,
                                                  input logic [ALU_OP_WIDTH-1:0] op);
        logic [DATA_WIDTH-1:0] z;
        logic ovf;
        ovf = 1'b0;
        case (op)
            ALU_ADD: begin z = a + b; ovf = (a[15] == b[15]) && (z[15] != a[15]); end
            ALU_SUB: begin z = a - b; ovf = (a[15] != b[15]) && (z[15] != a[15]); end
            ALU_AND: z = a & b;
            ALU_OR:  z = a | b;
            default: z = '0;
        endcase
        return {ovf, z};
    endfunction

    assign alu_rst_n = ~rst;
    always @(posedge clk) begin
        if (!alu_rst_n) {alu_ovf, alu_z} <= '0;
        else            {alu_ovf, alu_z} <= alu_f(alu_a, alu_b, alu_op);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, b, input logic [3:0] op, tag);
        io.req_valid = v;
        io.req_a     = a;
        io.req_b     = b;
        io.req_op    = op;
        io.req_tag   = tag;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        io.rsp_ready = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
        tick();
        tick();
        rst = 1'b0;
        checks++; if (io.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", io.req_ready); end
        checks++; if (io.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", io.rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_op !== 4'h0) begin errors++; $display("FAIL reset_alu_regs: got %h %h %h want 0 0 0", alu_a, alu_b, alu_op); end
        checks++; if (io.rsp_z !== 16'h0 || io.rsp_ovf !== 1'b0 || io.rsp_tag !== 4'h0) begin errors++; $display("FAIL reset_rsp_fields: got %h %b %h want 0 0 0", io.rsp_z, io.rsp_ovf, io.rsp_tag); end
    endtask

    task automatic test_single_op();
        io.rsp_ready = 1'b1;
        drive(1'b1, 16'd5, 16'd3, ALU_ADD, 4'd1);
        tick();
        io.req_valid = 1'b0;
        checks++; if (io.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_t0: got %b want 0", io.rsp_valid); end
        for (int k = 1; k <= LAT; k++) begin
            tick();
            checks++;
            if (io.rsp_valid !== (k == LAT)) begin errors++; $display("FAIL single_latency edge+%0d: got %b want %b", k, io.rsp_valid, (k == LAT)); end
        end
        checks++; if (io.rsp_z !== 16'd8 || io.rsp_ovf !== 1'b0 || io.rsp_tag !== 4'd1) begin errors++; $display("FAIL single_result: got z=%0d ovf=%b tag=%0d want 8 0 1", io.rsp_z, io.rsp_ovf, io.rsp_tag); end
        checks++; if (alu_a !== 16'd5 || alu_b !== 16'd3) begin errors++; $display("FAIL single_alu_hold: got %0d %0d want 5 3", alu_a, alu_b); end
        tick();
        checks++; if (io.rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_drain: got valid=%b busy=%b want 0 0", io.rsp_valid, busy); end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, first = -1, last = -1;
        logic fire;
        io.rsp_ready = 1'b1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            if (io.rsp_valid) begin
                checks++;
                if (io.rsp_tag !== 4'(got) || io.rsp_z !== 16'(got * 4 + 100)) begin
                    errors++; $display("FAIL b2b_rsp #%0d: got tag=%0d z=%0d want tag=%0d z=%0d", got, io.rsp_tag, io.rsp_z, got, got * 4 + 100);
                end
                if (first < 0) first = c;
                last = c;
                got++;
            end
            drive(sent < 8, 16'(sent * 3), 16'(sent + 100), ALU_ADD, 4'(sent));
            fire = io.req_valid && io.req_ready;
            tick();
            if (fire) sent++;
        end
        io.req_valid = 1'b0;
        checks++; if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", got); end
        checks++; if (last - first != 7) begin errors++; $display("FAIL b2b_consecutive: span %0d want 7", last - first); end
    endtask

    task automatic test_backpressure();
        int sent = 0, got = 0;
        logic fire;
        io.rsp_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            drive(sent < 10, 16'(sent * 3), 16'(sent + 100), ALU_ADD, 4'(sent));
            fire = io.req_valid && io.req_ready;
            tick();
            if (fire) sent++;
        end
        checks++; if (sent != 8) begin errors++; $display("FAIL bp_accepted: got %0d want 8", sent); end
        checks++; if (io.req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready: got %b want 0", io.req_ready); end
        checks++; if (io.rsp_valid !== 1'b1 || io.rsp_tag !== 4'd0 || io.rsp_z !== 16'd100) begin errors++; $display("FAIL bp_head_hold: got valid=%b tag=%0d z=%0d want 1 0 100", io.rsp_valid, io.rsp_tag, io.rsp_z); end
        io.rsp_ready = 1'b1;
        for (int c = 0; c < 60 && got < 10; c++) begin
            if (io.rsp_valid) begin
                checks++;
                if (io.rsp_tag !== 4'(got) || io.rsp_z !== 16'(got * 4 + 100)) begin
                    errors++; $display("FAIL bp_rsp #%0d: got tag=%0d z=%0d want tag=%0d z=%0d", got, io.rsp_tag, io.rsp_z, got, got * 4 + 100);
                end
                got++;
            end
            drive(sent < 10, 16'(sent * 3), 16'(sent + 100), ALU_ADD, 4'(sent));
            fire = io.req_valid && io.req_ready;
            tick();
            if (fire) sent++;
        end
        io.req_valid = 1'b0;
        checks++; if (got != 10 || sent != 10) begin errors++; $display("FAIL bp_total: got rsp=%0d sent=%0d want 10 10", got, sent); end
    endtask

    task automatic test_overflow();
        logic [15:0] a_v [2] = '{16'h7FFF, 16'h8000};
        logic [3:0]  o_v [2] = '{ALU_ADD, ALU_SUB};
        logic [15:0] z_v [2] = '{16'h8000, 16'h7FFF};
        int n;
        io.rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, a_v[i], 16'h0001, o_v[i], 4'(5 + i));
            tick();
            io.req_valid = 1'b0;
            n = 0;
            while (!io.rsp_valid && n < 10) begin tick(); n++; end
            checks++;
            if (io.rsp_valid !== 1'b1) begin errors++; $display("FAIL ovf_timeout #%0d: got valid=%b want 1", i, io.rsp_valid); end
            else if (io.rsp_z !== z_v[i] || io.rsp_ovf !== 1'b1 || io.rsp_tag !== 4'(5 + i)) begin
                errors++; $display("FAIL ovf_result #%0d: got z=%h ovf=%b tag=%0d want z=%h ovf=1 tag=%0d", i, io.rsp_z, io.rsp_ovf, io.rsp_tag, z_v[i], 5 + i);
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        logic seen = 1'b0;
        io.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(i), 16'd1, ALU_ADD, 4'(i + 8));
            tick();
        end
        io.req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || io.req_ready !== 1'b1 || io.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_state: got busy=%b ready=%b valid=%b want 0 1 0", busy, io.req_ready, io.rsp_valid); end
        for (int k = 0; k < 8; k++) begin
            tick();
            if (io.rsp_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_ghost_rsp: got %b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
